// File: rtl/uart_word_packer_if.sv
// ---------------------------------------------------------------------------
// uart_word_packer_if
//
// Word-stream bus between the UART word packer and the program/data loader.
//
// Signals:
//   word        32  head-of-FIFO word (little-endian packed bytes)
//   word_valid   1  producer holds at least one finished word
//   word_ready   1  consumer can take the word this cycle
//
// Handshake: a word moves on every rising clock edge where word_valid and
// word_ready are both 1. The producer holds word stable while word_valid
// is 1 and word_ready is 0. word_valid never depends combinationally on
// word_ready, so the consumer may assert word_ready at any time.
//
// Modports:
//   master  producer side (the packer)
//   slave   consumer side (the loader)
// ---------------------------------------------------------------------------
interface uart_word_packer_if;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output word,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/uart_word_packer.sv
// ---------------------------------------------------------------------------
// uart_word_packer
//
// Sits behind the UART receiver. Accepts the one-cycle byte strobe, packs four
// consecutive good bytes little-endian into a 32-bit word (first byte in
// bits [7:0]) and queues finished words in a small circular FIFO, so the
// loader can stall without losing serial data.
//
// Parameters:
//   DEPTH         word FIFO depth, power of two in 2..16
//   TIMEOUT_CLKS  idle clocks before a partial word is discarded
//                 (only used when UART_PACK_TIMEOUT_EN is defined)
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rstn         in   1  asynchronous active-low reset
//   rdata        in   8  received byte, meaningful only with rdata_ready
//   rdata_ready  in   1  one-cycle byte strobe from the receiver
//   ferr         in   1  one-cycle framing-error strobe (may coincide with
//                        rdata_ready for the same frame)
//   clr          in   1  synchronous clear of overflow and ferr_cnt
//   wbus         master modport of uart_word_packer_if
//                        (word / word_valid / word_ready)
//   overflow     out  1  sticky: a finished word was lost to a full FIFO
//   ferr_cnt     out  8  saturating framing-error count
//   timeout      out  1  one-cycle pulse: a partial word was discarded
//
// Build option:
//   UART_PACK_TIMEOUT_EN  when defined, a partial word that sits idle for
//                         TIMEOUT_CLKS clocks is thrown away and timeout
//                         pulses. When undefined, partial words are held
//                         indefinitely and timeout is tied to 0.
// ---------------------------------------------------------------------------
module uart_word_packer #(
  parameter int DEPTH        = 4,
  parameter int TIMEOUT_CLKS = 104160
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [7:0]                 rdata,
  input  logic                       rdata_ready,
  input  logic                       ferr,
  input  logic                       clr,
  uart_word_packer_if.master         wbus,
  output logic                       overflow,
  output logic [7:0]                 ferr_cnt,
  output logic                       timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]    byte_idx_q, byte_idx_d;
  // Only the first three lanes need storage: the fourth byte goes straight
  // from rdata into the FIFO on the completing strobe.
  logic [23:0]   lanes_q, lanes_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    ferr_cnt_q, ferr_cnt_d;

  // ---------------------------------------------------------------------
  // Per-cycle events
  // ---------------------------------------------------------------------
  logic        accept;     // good byte this cycle
  logic        push_req;   // this byte completes a word
  logic        push;       // completed word actually enters the FIFO
  logic        pop;        // consumer takes the head word
  logic        fifo_full;
  logic        fifo_empty;
  logic        drop;       // completed word lost because the FIFO is full
  logic        expire;     // partial word discarded by the idle timer
  logic [31:0] push_word;

  // A framing error never stores a byte, even when the receiver also
  // raised rdata_ready for the same frame.
  assign accept     = rdata_ready & ~ferr;
  assign push_req   = accept & (byte_idx_q == 2'd3);
  assign push_word  = {rdata, lanes_q};
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign pop        = ~fifo_empty & wbus.word_ready;
  // A full FIFO still takes the new word when the head leaves in the same
  // cycle, so occupancy stays at DEPTH without loss.
  assign push       = push_req & (~fifo_full | pop);
  assign drop       = push_req & fifo_full & ~pop;

  // ---------------------------------------------------------------------
  // Optional idle timer for partial words
  // ---------------------------------------------------------------------
`ifdef UART_PACK_TIMEOUT_EN
  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CLKS - 1);

  logic [31:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;

  // Any strobe (good or bad) restarts the idle window, and it wins over an
  // expiry that lands in the same cycle. The timer only runs while a word
  // is partially assembled.
  always_comb begin
    idle_d = idle_q;
    expire = 1'b0;
    if (rdata_ready | ferr) begin
      idle_d = '0;
    end else if (byte_idx_q != 2'd0) begin
      if (idle_q == IDLE_LAST) begin
        expire = 1'b1;
        idle_d = '0;
      end else begin
        idle_d = idle_q + 32'd1;
      end
    end
    timeout_d = expire;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Byte assembly
  // ---------------------------------------------------------------------
  always_comb begin
    byte_idx_d = byte_idx_q;
    lanes_d    = lanes_q;
    if (accept) begin
      // byte_idx wraps to 0 after the fourth byte, whether or not the
      // finished word found room in the FIFO.
      byte_idx_d = byte_idx_q + 2'd1;
      if (byte_idx_q != 2'd3) begin
        lanes_d[{byte_idx_q, 3'b000} +: 8] = rdata;
      end
    end else if (expire) begin
      byte_idx_d = 2'd0;
      lanes_d    = '0;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // Status: sticky overflow and saturating framing-error count.
  // clr is applied last so it overrides a same-cycle increment.
  // ---------------------------------------------------------------------
  always_comb begin
    overflow_d = overflow_q | drop;
    ferr_cnt_d = ferr_cnt_q;
    if (ferr && (ferr_cnt_q != 8'hFF)) begin
      ferr_cnt_d = ferr_cnt_q + 8'd1;
    end
    if (clr) begin
      overflow_d = 1'b0;
      ferr_cnt_d = 8'd0;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_idx_q <= 2'd0;
      lanes_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ferr_cnt_q <= 8'd0;
    end else begin
      byte_idx_q <= byte_idx_d;
      lanes_q    <= lanes_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      ferr_cnt_q <= ferr_cnt_d;
    end
  end

  // Storage is cleared on reset so the head word reads 0 out of reset
  // instead of stale data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wptr_q] <= push_word;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: the head word is read straight from storage, no bypass, so a
  // freshly pushed word is visible one cycle after its completing strobe.
  // ---------------------------------------------------------------------
  assign wbus.word       = mem_q[rptr_q];
  assign wbus.word_valid = ~fifo_empty;
  assign overflow        = overflow_q;
  assign ferr_cnt        = ferr_cnt_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// ---------------------------------------------------------------------------
// tb_uart_word_packer
//
// Directed bench for uart_word_packer (DEPTH=4, TIMEOUT_CLKS=100).
// Inputs change on the falling edge; outputs are sampled on the falling
// edge, half a cycle away from the rising edge the DUT uses.
// ---------------------------------------------------------------------------
module tb_uart_word_packer;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic       clk;
  logic       rstn;
  logic [7:0] rdata;
  logic       rdata_ready;
  logic       ferr;
  logic       clr;
  logic       overflow;
  logic [7:0] ferr_cnt;
  logic       timeout;

  uart_word_packer_if wb ();

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_word_packer #(
    .DEPTH        (4),
    .TIMEOUT_CLKS (100)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rdata       (rdata),
    .rdata_ready (rdata_ready),
    .ferr        (ferr),
    .clr         (clr),
    .wbus        (wb),
    .overflow    (overflow),
    .ferr_cnt    (ferr_cnt),
    .timeout     (timeout)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // -------------------------------------------------------------------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (all return on a falling edge)
  // -------------------------------------------------------------------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One idle cycle, then a one-cycle strobe; returns just after the edge
  // that sampled the strobe.
  task automatic send_byte(input logic [7:0] b, input logic fe);
    step(1);
    rdata       = b;
    rdata_ready = 1'b1;
    ferr        = fe;
    step(1);
    rdata_ready = 1'b0;
    ferr        = 1'b0;
  endtask

  task automatic send_ferr_only();
    step(1);
    ferr = 1'b1;
    step(1);
    ferr = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0],   1'b0);
    send_byte(w[15:8],  1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[31:24], 1'b0);
  endtask

  task automatic pop_one();
    wb.word_ready = 1'b1;
    step(1);
    wb.word_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Vector table: four good bytes, optionally a framing-error strobe after
  // the first byte (1 = ferr together with rdata_ready, 2 = ferr alone).
  // exp_fcnt is the running framing-error count after the vector.
  // -------------------------------------------------------------------------
  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [1:0]  ferr_mode;
    logic [31:0] exp_word;
    logic [7:0]  exp_fcnt;
  } vec_t;

  vec_t vecs[5];

  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 2'd0, 32'h12345678, 8'd0};
    vecs[1] = '{8'h11, 8'h22, 8'h33, 8'h44, 2'd1, 32'h44332211, 8'd1};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 2'd0, 32'hFF00FF00, 8'd1};
    vecs[3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 2'd2, 32'hEFBEADDE, 8'd2};
    vecs[4] = '{8'h01, 8'h02, 8'h03, 8'h04, 2'd0, 32'h04030201, 8'd2};

    rstn          = 1'b0;
    rdata         = 8'h00;
    rdata_ready   = 1'b0;
    ferr          = 1'b0;
    clr           = 1'b0;
    wb.word_ready = 1'b0;

    // ---- reset state ------------------------------------------------------
    step(3);
    chk("reset word_valid", {31'b0, wb.word_valid}, 32'd0);
    chk("reset word",       wb.word,                32'd0);
    chk("reset overflow",   {31'b0, overflow},      32'd0);
    chk("reset ferr_cnt",   {24'b0, ferr_cnt},      32'd0);
    chk("reset timeout",    {31'b0, timeout},       32'd0);
    rstn = 1'b1;
    step(2);

    // ---- basic word, consumer always ready -------------------------------
    wb.word_ready = 1'b1;
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    chk("basic valid before 4th", {31'b0, wb.word_valid}, 32'd0);
    send_byte(8'h12, 1'b0);
    chk("basic valid after 4th", {31'b0, wb.word_valid}, 32'd1);
    chk("basic word",            wb.word,                32'h12345678);
    step(1);
    chk("basic valid one cycle", {31'b0, wb.word_valid}, 32'd0);
    wb.word_ready = 1'b0;

    // ---- table-driven words ----------------------------------------------
    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].b0, 1'b0);
      if (vecs[i].ferr_mode == 2'd1) send_byte(8'hEE, 1'b1);
      if (vecs[i].ferr_mode == 2'd2) send_ferr_only();
      send_byte(vecs[i].b1, 1'b0);
      send_byte(vecs[i].b2, 1'b0);
      send_byte(vecs[i].b3, 1'b0);
      chk($sformatf("vec%0d valid", i),    {31'b0, wb.word_valid}, 32'd1);
      chk($sformatf("vec%0d word", i),     wb.word,                vecs[i].exp_word);
      chk($sformatf("vec%0d ferr_cnt", i), {24'b0, ferr_cnt},      {24'b0, vecs[i].exp_fcnt});
      pop_one();
      chk($sformatf("vec%0d drained", i),  {31'b0, wb.word_valid}, 32'd0);
    end

    // ---- overflow: five words into a four-deep FIFO ----------------------
    exp_q = {};
    for (int i = 1; i <= 5; i++) begin
      send_word(32'h11111111 * i);
      if (i == 4) chk("ovf before 5th", {31'b0, overflow}, 32'd0);
      if (i <= 4) exp_q.push_back(32'h11111111 * i);
    end
    chk("ovf sticky set", {31'b0, overflow}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      exp_w = exp_q.pop_front();
      chk($sformatf("ovf drain%0d valid", i), {31'b0, wb.word_valid}, 32'd1);
      chk($sformatf("ovf drain%0d word", i),  wb.word,                exp_w);
      pop_one();
    end
    chk("ovf drained empty", {31'b0, wb.word_valid}, 32'd0);
    chk("ovf still sticky",  {31'b0, overflow},      32'd1);
    pulse_clr();
    chk("clr overflow", {31'b0, overflow}, 32'd0);
    chk("clr ferr_cnt", {24'b0, ferr_cnt}, 32'd0);

    // ---- ferr_cnt saturation and clr priority ----------------------------
    for (int i = 0; i < 260; i++) send_ferr_only();
    chk("ferr_cnt saturates", {24'b0, ferr_cnt}, 32'd255);
    step(1);
    ferr = 1'b1;
    clr  = 1'b1;
    step(1);
    ferr = 1'b0;
    clr  = 1'b0;
    chk("clr beats ferr", {24'b0, ferr_cnt}, 32'd0);

    // ---- full FIFO, push and pop in the same cycle -----------------------
    exp_q = {};
    for (int i = 1; i <= 4; i++) begin
      send_word(32'hB0000000 + i);
      exp_q.push_back(32'hB0000000 + i);
    end
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    step(1);
    rdata         = 8'hB0;
    rdata_ready   = 1'b1;
    wb.word_ready = 1'b1;
    step(1);
    rdata_ready   = 1'b0;
    wb.word_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(32'hB0000005);
    chk("full push+pop no overflow", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_w = exp_q.pop_front();
      chk($sformatf("full drain%0d valid", i), {31'b0, wb.word_valid}, 32'd1);
      chk($sformatf("full drain%0d word", i),  wb.word,                exp_w);
      pop_one();
    end
    chk("full count was 4", {31'b0, wb.word_valid}, 32'd0);

    // ---- empty FIFO, ready held through the completing strobe ------------
    wb.word_ready = 1'b1;
    send_word(32'hC0FFEE00);
    chk("empty push+pop valid", {31'b0, wb.word_valid}, 32'd1);
    chk("empty push+pop word",  wb.word,                32'hC0FFEE00);
    step(1);
    chk("empty push+pop popped", {31'b0, wb.word_valid}, 32'd0);
    wb.word_ready = 1'b0;

    // ---- asynchronous reset mid-word with a word held --------------------
    send_ferr_only();
    send_word(32'hCAFEBABE);
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    chk("pre-reset valid", {31'b0, wb.word_valid}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async reset valid",    {31'b0, wb.word_valid}, 32'd0);
    chk("async reset word",     wb.word,                32'd0);
    chk("async reset ferr_cnt", {24'b0, ferr_cnt},      32'd0);
    chk("async reset overflow", {31'b0, overflow},      32'd0);
    step(1);
    rstn = 1'b1;
    send_word(32'h40302010);
    chk("post-reset fresh word", wb.word,                32'h40302010);
    chk("post-reset valid",      {31'b0, wb.word_valid}, 32'd1);
    pop_one();

    // ---- partial-word idle behaviour -------------------------------------
`ifdef UART_PACK_TIMEOUT_EN
    send_byte(8'hAA, 1'b0);
    step(99);
    chk("timeout not yet", {31'b0, timeout}, 32'd0);
    step(1);
    chk("timeout pulse", {31'b0, timeout}, 32'd1);
    step(1);
    chk("timeout one cycle", {31'b0, timeout}, 32'd0);
    send_word(32'h04030201);
    chk("after timeout word", wb.word, 32'h04030201);
    pop_one();
    // Strobe lands exactly on the expiry cycle: it wins.
    send_byte(8'h55, 1'b0);
    step(98);
    send_byte(8'h66, 1'b0);
    chk("strobe at expiry no timeout", {31'b0, timeout}, 32'd0);
    step(2);
    chk("strobe at expiry no late pulse", {31'b0, timeout}, 32'd0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    chk("strobe at expiry word kept", wb.word, 32'h88776655);
    pop_one();
`else
    send_byte(8'hAA, 1'b0);
    step(150);
    chk("no timeout pulse", {31'b0, timeout}, 32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    chk("partial held valid", {31'b0, wb.word_valid}, 32'd1);
    chk("partial held word",  wb.word,                32'h030201AA);
    pop_one();
    send_byte(8'h04, 1'b0);
    chk("new partial not valid", {31'b0, wb.word_valid}, 32'd0);
`endif

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_word_packer.md
Name: uart_word_packer

Overview:
- Sits directly downstream of the UART receiver and consumes its one-cycle byte strobe, received byte and framing-error flag.
- Packs four consecutive good bytes, little-endian, into a 32-bit word for the core's program/data loader.
- Buffers finished words in a small circular FIFO presented on a valid/ready interface, so the loader can stall without losing serial data.

Parameters:
- DEPTH, 4: word FIFO depth; power of two, 2..16.
- TIMEOUT_CLKS, 104160: idle clocks before a partial word is discarded (timeout feature only; 10 bit times at 5208 clk/half-bit).

Ports:
- clk  input  1  system clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- rdata  input  8  received byte, valid only when rdata_ready=1
- rdata_ready  input  1  one-cycle byte strobe from receiver
- ferr  input  1  one-cycle framing-error strobe from receiver; may coincide with rdata_ready for the same frame
- word  output  32  head-of-FIFO word
- word_valid  output  1  FIFO non-empty
- word_ready  input  1  consumer accepts word when word_valid & word_ready
- overflow  output  1  sticky: a completed word was lost because the FIFO was full
- ferr_cnt  output  8  saturating count of framing errors
- timeout  output  1  one-cycle pulse: partial word discarded (timeout feature only, else tied 0)
- clr  input  1  synchronous clear of overflow and ferr_cnt

Behaviour:
- Reset (async, rstn=0): byte_idx=0, shift reg=0, FIFO ptrs/count=0, word=0, word_valid=0, overflow=0, ferr_cnt=0, timeout=0. Any partial word and all FIFO contents are discarded.
- Byte accept: on rdata_ready=1 and ferr=0, store the byte into lane byte_idx (byte 0 -> bits [7:0] ... byte 3 -> [31:24]); byte_idx increments mod 4.
- Bad frame: ferr=1 (with or without rdata_ready) -> byte is not stored, byte_idx unchanged, ferr_cnt+1 saturating at 255. A framing error does not break word alignment.
- Word completion: the cycle the 4th byte is accepted, the assembled word is pushed into the FIFO. word_valid rises the next cycle (1-cycle latency from the 4th strobe).
- Push while full, with no pop that cycle: word dropped, overflow<=1, FIFO unchanged, byte_idx still wraps to 0.
- Push and pop in the same cycle while full: both occur; no overflow, count unchanged.
- Pop: word_valid & word_ready -> rptr+1 mod DEPTH. word always shows the mem[rptr] head; it is undefined-but-stable when word_valid=0.
- Pop and push in the same cycle while empty: the pushed word appears next cycle; no bypass.
- Pointers: log2(DEPTH) bits plus a count register of log2(DEPTH)+1 bits. Full = count==DEPTH, empty = count==0.
- clr=1: overflow<=0, ferr_cnt<=0. Priority: clr takes effect after same-cycle increments, so clr wins.
- Inputs rdata_ready and ferr are single-cycle pulses spaced at least one bit time apart; the block need not handle back-to-back strobes, but must remain correct if they occur.

Optional Feature:
- Macro UART_PACK_TIMEOUT_EN.
- Defined:
  - A 32-bit idle counter resets on every rdata_ready or ferr strobe and increments only while byte_idx != 0.
  - When it reaches TIMEOUT_CLKS-1: byte_idx<=0, shift reg<=0, timeout pulses 1 for one cycle, counter<=0.
  - A strobe arriving in the same cycle as expiry wins: the counter resets, the byte is accepted, and there is no timeout.
- Not defined: no counter; timeout tied to 0; partial words are held indefinitely.

Test Plan:
- Bytes 0x78,0x56,0x34,0x12 with word_ready=1 -> word_valid for 1 cycle starting 1 clk after the 4th strobe, word=0x12345678.
- Bytes 0x11, ferr strobe, 0x22,0x33,0x44 -> word=0x44332211, ferr_cnt=1.
- word_ready=0, send 5 words (DEPTH=4) -> 4 words held, overflow=1; drain gives words 1..4 in order; then clr=1 -> overflow=0, ferr_cnt=0.
- FIFO full with word_ready=1 in the same cycle the 4th byte arrives -> no overflow, count stays 4, order preserved.
- Assert rstn=0 after 2 bytes and mid-drain -> all outputs zero immediately (asynchronously); the next 4 bytes form a fresh word.
- With UART_PACK_TIMEOUT_EN and TIMEOUT_CLKS=100: send 0xAA then idle 100 clks -> timeout pulse; then 0x01,0x02,0x03,0x04 -> word=0x04030201.
